// File: rtl/sntc_ldpc_ctrl_pkg.sv
// sntc_ldpc_ctrl_pkg: controller state encoding and a width-bounded popcount helper
package sntc_ldpc_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, CHECK, FLIP, DONE} state_t;
    localparam int POP_MAX = 1024;
    function automatic int unsigned popcount(input logic [POP_MAX-1:0] v, input int unsigned width);
        int unsigned c;
        c = 0;
        for (int i = 0; i < POP_MAX; i++) c += (i < int'(width)) ? 32'(v[i]) : 32'd0;
        return c;
    endfunction
endpackage

// File: rtl/sntc_ldpc_syn_weight.sv
// sntc_ldpc_syn_weight: combinational syndrome weight (popcount of MM bits)
module sntc_ldpc_syn_weight
    import sntc_ldpc_ctrl_pkg::*;
#(
    parameter int MM     = 'h000a8,
    parameter int SUM_MM = $clog2(MM + 1)
) (
    input  logic [MM-1:0]     vec,
    output logic [SUM_MM-1:0] wt
);
    assign wt = SUM_MM'(popcount(POP_MAX'(vec), MM));
endmodule

// File: rtl/sntc_ldpc_decode_ctrl.sv
// sntc_ldpc_decode_ctrl: LDPC check/flip sequencer; stats counters enabled by SNTC_LDPC_CTRL_STATS_EN
module sntc_ldpc_decode_ctrl
    import sntc_ldpc_ctrl_pkg::*;
#(
    parameter int MM      = 'h000a8,
    parameter int NN      = 'h000d0,
    parameter int ITER_W  = 6,
    parameter int SYN_LAT = 0,
    parameter int SUM_MM  = $clog2(MM + 1),
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NN-1:0]     in_cword,
    input  logic [ITER_W-1:0] max_iter,
    output logic [NN-1:0]     syn_y,
    input  logic [MM-1:0]     syn_vec,
    input  logic              syn_valid_cword,
    output logic              eng_start,
    output logic [NN-1:0]     eng_cword,
    input  logic              eng_done,
    input  logic [NN-1:0]     eng_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NN-1:0]     out_cword,
    output logic              out_ok,
    output logic [ITER_W-1:0] out_iters,
    output logic [SUM_MM-1:0] out_syn_wt,
    output logic [CNT_W-1:0]  stat_ok,
    output logic [CNT_W-1:0]  stat_fail
);
    localparam int DW_W = $clog2(SYN_LAT + 2);

    state_t              state, state_nx;
    logic [NN-1:0]       y_reg;
    logic [ITER_W-1:0]   lim, iter;
    logic [DW_W-1:0]     dwell;
    logic [SUM_MM-1:0]   syn_wt;
    logic                decide, accept, reload, release_w;

    sntc_ldpc_syn_weight #(.MM(MM), .SUM_MM(SUM_MM)) u_wt (.vec(syn_vec), .wt(syn_wt));

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign syn_y     = y_reg;
    assign eng_cword = y_reg;
    assign out_cword = y_reg;
    assign decide    = state == CHECK && dwell == DW_W'(SYN_LAT);
    assign accept    = in_ready && in_valid && !clr;
    assign reload    = state == FLIP && eng_done && !clr;
    assign release_w = out_valid && out_ready && !clr;

    always_comb begin
        state_nx  = state;
        eng_start = 1'b0;
        case (state)
            IDLE:  state_nx = in_valid ? CHECK : IDLE;
            CHECK: if (decide) begin
                state_nx  = (syn_valid_cword || iter == lim) ? DONE : FLIP;
                eng_start = !syn_valid_cword && iter != lim;
            end
            FLIP:  state_nx = eng_done ? CHECK : FLIP;
            DONE:  state_nx = out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
        if (clr || rst) begin
            state_nx  = IDLE;
            eng_start = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            y_reg      <= '0;
            lim        <= '0;
            iter       <= '0;
            dwell      <= '0;
            out_ok     <= 1'b0;
            out_iters  <= '0;
            out_syn_wt <= '0;
        end else begin
            state <= state_nx;
            if (state == CHECK && !decide) dwell <= dwell + DW_W'(1);
            if (accept) begin
                y_reg <= in_cword;
                lim   <= max_iter;
                iter  <= '0;
                dwell <= '0;
            end
            if (decide && !clr) begin
                out_ok     <= syn_valid_cword;
                out_iters  <= iter;
                out_syn_wt <= syn_wt;
            end
            if (reload) begin
                y_reg <= eng_result;
                iter  <= iter + ITER_W'(1);
                dwell <= '0;
            end
        end
    end

`ifdef SNTC_LDPC_CTRL_STATS_EN
    logic [CNT_W-1:0] ok_cnt, fail_cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            ok_cnt   <= '0;
            fail_cnt <= '0;
        end else if (release_w) begin
            if (out_ok && !(&ok_cnt)) ok_cnt <= ok_cnt + CNT_W'(1);
            if (!out_ok && !(&fail_cnt)) fail_cnt <= fail_cnt + CNT_W'(1);
        end
    end
    assign stat_ok   = ok_cnt;
    assign stat_fail = fail_cnt;
`else
    assign stat_ok   = '0;
    assign stat_fail = '0;
`endif
endmodule
